// File: rtl/branch_predict_unit.sv
// Conditional-branch resolution for BEQ/BNE/BGEZ in EX, a direct-mapped table of
// 2-bit saturating counters read by IF, and a registered one-cycle mispredict flush.
module branch_predict_unit #(
  parameter int          ADDR_W   = 32,
  parameter int          IDX_W    = 4,
  parameter logic [1:0]  CTR_INIT = 2'b01,
  parameter int          CNT_W    = 16
) (
  input  logic              in_clk,
  input  logic              in_rst,
  input  logic [ADDR_W-1:0] in_fetch_pc,
  output logic              out_pred_taken,
  input  logic              in_res_valid,
  input  logic [ADDR_W-1:0] in_res_pc,
  input  logic [5:0]        in_opcode,
  input  logic              in_special,
  input  logic              in_eq,
  input  logic              in_sign,
  input  logic [ADDR_W-1:0] in_target,
  input  logic              in_pred_taken,
  input  logic              in_clr_stats,
  output logic              out_flush,
  output logic [ADDR_W-1:0] out_redirect_pc,
  output logic [CNT_W-1:0]  out_branch_cnt,
  output logic [CNT_W-1:0]  out_miss_cnt
);

  localparam int DEPTH = 1 << IDX_W;

  typedef enum logic [5:0] {
    OP_BGEZ = 6'b000001,
    OP_BEQ  = 6'b000100,
    OP_BNE  = 6'b000101
  } br_op_e;

  logic [1:0]       ctr_table [DEPTH];
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] res_idx;
  logic             is_cb;
  logic             actual;
  logic             resolve;
  logic             mispredict;
  logic [1:0]       ctr_cur;
  logic [1:0]       ctr_next;
  logic             unused_pc_bits;

  assign fetch_idx      = in_fetch_pc[IDX_W+1:2];
  assign res_idx        = in_res_pc[IDX_W+1:2];
  assign out_pred_taken = ctr_table[fetch_idx][1];
  assign unused_pc_bits = ^{in_fetch_pc[ADDR_W-1:IDX_W+2], in_fetch_pc[1:0]};

  // NOTE: every variable driven here gets a default first so no latch is inferred.
  always_comb begin
    is_cb  = 1'b0;
    actual = 1'b0;
    if (!in_special) begin
      case (in_opcode)
        OP_BEQ:  begin is_cb = 1'b1; actual = in_eq;    end
        OP_BNE:  begin is_cb = 1'b1; actual = ~in_eq;   end
        OP_BGEZ: begin is_cb = 1'b1; actual = ~in_sign; end
        default: ;
      endcase
    end
  end

  assign resolve    = in_res_valid & is_cb;
  assign mispredict = resolve & (actual != in_pred_taken);
  assign ctr_cur    = ctr_table[res_idx];

  always_comb begin
    ctr_next = ctr_cur;
    if (actual && ctr_cur != 2'b11)
      ctr_next = ctr_cur + 2'b01;
    else if (!actual && ctr_cur != 2'b00)
      ctr_next = ctr_cur - 2'b01;
  end

  // NOTE: the table is a small register array, so every entry is reset explicitly;
  // a RAM-based table would instead need an init sequencer.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      for (int i = 0; i < DEPTH; i++) ctr_table[i] <= CTR_INIT;
    end else if (resolve) begin
      ctr_table[res_idx] <= ctr_next;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers sample
  // pre-edge values.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      out_flush       <= 1'b0;
      out_redirect_pc <= '0;
    end else if (mispredict) begin
      out_flush       <= 1'b1;
      out_redirect_pc <= actual ? in_target : in_res_pc + ADDR_W'(4);
    end else begin
      out_flush       <= 1'b0;
    end
  end

  // Clear wins over a same-cycle increment; counters stick at all-ones.
  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      out_branch_cnt <= '0;
      out_miss_cnt   <= '0;
    end else if (in_clr_stats) begin
      out_branch_cnt <= '0;
      out_miss_cnt   <= '0;
    end else begin
      if (resolve && out_branch_cnt != '1) out_branch_cnt <= out_branch_cnt + 1'b1;
      if (mispredict && out_miss_cnt != '1) out_miss_cnt <= out_miss_cnt + 1'b1;
    end
  end

endmodule

// File: doc/branch_predict_unit.md
# branch_predict_unit

Conditional-branch resolution and 2-bit dynamic prediction block for the pipelined MIPS-subset CPU. It decodes the resolving instruction's opcode in EX and evaluates BEQ/BNE/BGEZ. It updates a direct-mapped table of saturating counters that IF reads combinationally, and it raises a registered one-cycle flush with a redirect PC on mispredict. Width, table depth and statistics width are parametrised; this replaces static not-taken branch handling in the jump-control path.

## Interface
- ADDR_W, 32, PC/target width (≥ IDX_W+2)
- IDX_W, 4, table index bits; table has 2^IDX_W entries
- CTR_INIT, 2'b01, reset value of every counter (weakly not-taken)
- CNT_W, 16, width of statistics counters

Ports:
- in_clk  input  1  clock, all state on rising edge
- in_rst  input  1  reset, asynchronous, active-high
- in_fetch_pc  input  ADDR_W  IF-stage PC for lookup
- out_pred_taken  output  1  prediction for in_fetch_pc (combinational from table)
- in_res_valid  input  1  EX holds a valid instruction this cycle
- in_res_pc  input  ADDR_W  PC of the EX instruction
- in_opcode  input  6  instruction[31:26] of the EX instruction
- in_special  input  1  opcode==000000 flag from main decoder
- in_eq  input  1  rs==rt from ALU comparator
- in_sign  input  1  rs[31]
- in_target  input  ADDR_W  computed branch target
- in_pred_taken  input  1  prediction carried down the pipe with this instruction
- in_clr_stats  input  1  synchronous clear of statistics
- out_flush  output  1  registered mispredict pulse
- out_redirect_pc  output  ADDR_W  correct next PC, valid while out_flush=1
- out_branch_cnt  output  CNT_W  resolved conditional branches
- out_miss_cnt  output  CNT_W  mispredicted conditional branches

## Operation
- Index = pc[IDX_W+1:2] for both lookup and update.
- out_pred_taken = table[idx(in_fetch_pc)][1].
- Conditional branch (is_cb) when in_special=0 and in_opcode ∈ {000100 BEQ, 000101 BNE, 000001 BGEZ}; all other opcodes, including J/JAL/JR, are ignored.
- actual = BEQ: in_eq; BNE: ~in_eq; BGEZ: ~in_sign.
- Resolve event = in_res_valid & is_cb. On the event:
  - table[idx(in_res_pc)] increments if actual=1 and decrements otherwise, saturating at 2'b11 and 2'b00.
  - out_branch_cnt increments.
  - If actual≠in_pred_taken: out_miss_cnt increments, out_flush←1, out_redirect_pc←actual ? in_target : in_res_pc+4 (mod 2^ADDR_W).
- Without a resolve event, out_flush←0; out_redirect_pc holds its value.
- Statistics counters saturate at all-ones and never wrap.
- in_clr_stats=1 zeroes both statistics counters and has priority over a same-cycle increment; it does not touch the table or flush.
- Reset: all table entries to CTR_INIT; out_flush=0, out_redirect_pc=0, both counters=0. out_pred_taken therefore reads CTR_INIT[1] (0 by default).

## Timing
- Lookup: zero latency, combinational within the IF cycle.
- Resolve→out_flush/out_redirect_pc: 1 cycle; the flag is visible in the cycle after the EX cycle and lasts exactly one cycle per mispredicting branch.
- Back-to-back mispredicts in consecutive cycles give consecutive flush cycles, each with its own redirect PC.
- Table update is visible to lookup from the cycle after the resolve edge. A same-cycle lookup of the index being updated returns the old value.
- Aliasing is permitted: distinct PCs with equal index share an entry.
- Asynchronous in_rst mid-operation clears out_flush immediately, without waiting for a clock edge, and restores all table entries; a resolve in the reset cycle is lost.
- in_res_valid=0 suppresses all updates regardless of the other inputs.

## Test plan
- Reset, in_fetch_pc=0x00400000 -> out_pred_taken=0, out_flush=0, both counters 0.
- BEQ at 0x00400010, in_eq=1, in_pred_taken=0, target 0x00400040 -> next cycle out_flush=1, out_redirect_pc=0x00400040, miss=1, branch=1. Lookup 0x00400010 afterwards -> 1 (counter 2).
- BNE at 0x00400020, in_eq=1, in_pred_taken=1 -> flush, redirect 0x00400024. A further 3 not-taken BNEs at the same PC -> counter saturates at 0, and no underflow to 3 occurs.
- BGEZ with in_sign=0, in_pred_taken=1 -> no flush, branch_cnt+1, miss unchanged. Opcode 000010 (J) with in_res_valid=1 -> no counter or table change.
- CNT_W=4: 17 mispredicts -> out_miss_cnt=15 (saturated). in_clr_stats asserted with a mispredict in the same cycle -> counters 0, flush still 1 next cycle.
- Assert in_rst while out_flush=1 -> out_flush drops before the next edge; a previously trained index reads 0 again.
